dma_bus_arbiter: RTL
====================

Name: dma_bus_arbiter

Overview:
Arbitrates the shared memory/IO bus between the CPU master and the DMA unit's master port.
Implements the DMA HOLD/HLDA handshake, so the DMA unit no longer loops hold_request straight back to hold_acknowledge.
Never switches owner mid-transaction, and bounds DMA bursts so the CPU cannot be starved.
Sits between the CPU bus interface, the DMA unit and the downstream memory/IO bus mux.

Parameters:
MAX_DMA_BURST, 4, DMA transfers (m_ack count) allowed per grant while the CPU is waiting; 0 = unlimited.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_m_addr  in  19  CPU address [19:1]
cpu_m_data_out  in  16  CPU write data
cpu_m_access  in  1  CPU request; held high until cpu_m_ack
cpu_m_wr_en  in  1  CPU write
cpu_d_io  in  1  CPU IO access
cpu_m_bytesel  in  2  CPU byte mask
cpu_m_ack  out  1  CPU transfer complete
cpu_m_data_in  out  16  read data to CPU
dma_hold_request  in  1  DMA HOLD
dma_hold_acknowledge  out  1  DMA HLDA, registered
dma_m_addr  in  19  DMA address [19:1]
dma_m_data_out  in  16  DMA write data
dma_m_access  in  1  DMA request; held until dma_m_ack
dma_m_wr_en  in  1  DMA write
dma_d_io  in  1  DMA IO access
dma_m_bytesel  in  2  DMA byte mask
dma_m_ack  out  1  DMA transfer complete
dma_m_data_in  out  16  read data to DMA
m_addr  out  19  shared bus address [19:1]
m_data_out  out  16  shared bus write data
m_access  out  1  shared bus request
m_wr_en  out  1  shared bus write
d_io  out  1  shared bus IO access
m_bytesel  out  2  shared bus byte mask
m_ack  in  1  shared bus completion
m_data_in  in  16  shared bus read data
bus_owner_dma  out  1  1 while DMA owns the bus (DMA_OWN)

Behaviour:
- One clock domain. Reset: state CPU_OWN, dma_hold_acknowledge=0, burst_cnt=0, bus_owner_dma=0. cpu_m_ack and dma_m_ack are 0 while reset is asserted.
- States: CPU_OWN, TO_DMA, DMA_OWN, CPU_SLOT.
- Owner mux is combinational from state:
  - CPU_OWN / CPU_SLOT: shared bus outputs = CPU inputs.
  - DMA_OWN: shared bus outputs = DMA inputs.
  - TO_DMA: m_access=0, m_wr_en=0, m_bytesel=0, addr/data=0.
- m_data_in is driven unchanged to both cpu_m_data_in and dma_m_data_in.
- cpu_m_ack = m_ack & (state is CPU_OWN or CPU_SLOT). dma_m_ack = m_ack & (state==DMA_OWN). Zero added latency.
- dma_hold_acknowledge = (state==DMA_OWN), registered. bus_owner_dma is identical.
- CPU_OWN -> TO_DMA when dma_hold_request & (!cpu_m_access | m_ack).
  - A CPU transaction in flight always completes first; CPU wins a same-cycle tie.
  - Back-to-back CPU requests cannot block DMA, because the switch happens on the ack edge.
- TO_DMA: exactly one turnaround cycle -> DMA_OWN. burst_cnt <= 0.
- DMA_OWN: burst_cnt increments on each m_ack and saturates at MAX_DMA_BURST.
  - If !dma_hold_request & (!dma_m_access | m_ack): -> CPU_OWN.
  - Else if MAX_DMA_BURST!=0 & cpu_m_access & m_ack & burst_cnt==MAX_DMA_BURST-1: -> CPU_SLOT. HLDA drops; the DMA holds its request pending.
  - A DMA access in flight is never cut off. An HLDA drop with dma_m_access still high only happens after that access is acked.
- CPU_SLOT: serves exactly one CPU transaction.
  - On m_ack, or if cpu_m_access is low: -> TO_DMA if dma_hold_request, else CPU_OWN.
- If dma_hold_request drops in TO_DMA: still enter DMA_OWN. It exits next cycle via the release rule.
- Reset mid-transaction: return to CPU_OWN immediately. The in-flight access is abandoned, no ack is forwarded, HLDA=0 next cycle.
- Outside DMA_OWN, DMA signals never reach the shared bus. In DMA_OWN, CPU signals never reach it.

Test Plan:
1. Reset, CPU read addr 0x12345 with m_ack after 2 cycles -> m_addr=0x12345, cpu_m_ack pulses once, HLDA stays 0.
2. CPU access in flight, HOLD asserted at cycle 0, m_ack at cycle 3 -> TO_DMA at cycle 4, HLDA=1 from cycle 5, m_access=0 in cycle 4.
3. HOLD and cpu_m_access rise in the same cycle from idle -> CPU serviced first, HLDA only after cpu_m_ack.
4. MAX_DMA_BURST=4, HOLD held, CPU waiting -> HLDA drops after 4th dma_m_ack. One CPU ack follows, then TO_DMA, then HLDA=1 again with burst_cnt=0.
5. MAX_DMA_BURST=0, CPU waiting, 10 DMA transfers -> HLDA never drops; CPU is acked only after HOLD is released.
6. Reset asserted in DMA_OWN with dma_m_access high -> next cycle state CPU_OWN, HLDA=0, no dma_m_ack.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter
// Description : Shared memory/IO bus arbiter between the CPU master and the
//               DMA master port. Runs the HOLD/HLDA handshake, never changes
//               owner mid-transaction, and caps DMA bursts while the CPU waits.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter #(
  parameter int MAX_DMA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU master
  input  logic [19:1] cpu_m_addr,
  input  logic [15:0] cpu_m_data_out,
  input  logic        cpu_m_access,
  input  logic        cpu_m_wr_en,
  input  logic        cpu_d_io,
  input  logic [1:0]  cpu_m_bytesel,
  output logic        cpu_m_ack,
  output logic [15:0] cpu_m_data_in,
  // DMA master
  input  logic        dma_hold_request,
  output logic        dma_hold_acknowledge,
  input  logic [19:1] dma_m_addr,
  input  logic [15:0] dma_m_data_out,
  input  logic        dma_m_access,
  input  logic        dma_m_wr_en,
  input  logic        dma_d_io,
  input  logic [1:0]  dma_m_bytesel,
  output logic        dma_m_ack,
  output logic [15:0] dma_m_data_in,
  // Shared bus
  output logic [19:1] m_addr,
  output logic [15:0] m_data_out,
  output logic        m_access,
  output logic        m_wr_en,
  output logic        d_io,
  output logic [1:0]  m_bytesel,
  input  logic        m_ack,
  input  logic [15:0] m_data_in,
  output logic        bus_owner_dma
);

  // Counter wide enough to hold MAX_DMA_BURST itself (saturation value).
  localparam int CNT_W = (MAX_DMA_BURST < 1) ? 1 : $clog2(MAX_DMA_BURST + 1);
  localparam bit BURST_LIMITED = (MAX_DMA_BURST != 0);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_DMA_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = BURST_LIMITED ? CNT_W'(MAX_DMA_BURST - 1) : '0;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    TO_DMA   = 2'd1,
    DMA_OWN  = 2'd2,
    CPU_SLOT = 2'd3
  } state_t;

  state_t           state;
  logic             hold_ack;
  logic [CNT_W-1:0] burst_cnt;

  logic cpu_side;
  assign cpu_side = (state == CPU_OWN) || (state == CPU_SLOT);

  // Ownership FSM; HLDA is registered and moves together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CPU_OWN;
      hold_ack  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        CPU_OWN: begin
          // Switch only when the CPU is idle or its access completes now.
          if (dma_hold_request && (!cpu_m_access || m_ack))
            state <= TO_DMA;
        end
        TO_DMA: begin
          // One dead cycle with the bus parked before DMA drives it.
          state     <= DMA_OWN;
          hold_ack  <= 1'b1;
          burst_cnt <= '0;
        end
        DMA_OWN: begin
          if (m_ack && (burst_cnt != BURST_MAX))
            burst_cnt <= burst_cnt + CNT_W'(1);
          if (!dma_hold_request && (!dma_m_access || m_ack)) begin
            state    <= CPU_OWN;
            hold_ack <= 1'b0;
          end else if (BURST_LIMITED && cpu_m_access && m_ack &&
                       (burst_cnt >= BURST_LAST)) begin
            // '>=' also covers a saturated count, so a CPU that starts
            // waiting after the burst budget is used up still gets a slot.
            state    <= CPU_SLOT;
            hold_ack <= 1'b0;
          end
        end
        CPU_SLOT: begin
          // Exactly one CPU transaction, then hand back if DMA still holds.
          if (m_ack || !cpu_m_access)
            state <= dma_hold_request ? TO_DMA : CPU_OWN;
        end
        default: begin
          state    <= CPU_OWN;
          hold_ack <= 1'b0;
        end
      endcase
    end
  end

  // Owner mux: only the current owner's signals reach the shared bus.
  always_comb begin
    m_addr     = '0;
    m_data_out = '0;
    m_access   = 1'b0;
    m_wr_en    = 1'b0;
    d_io       = 1'b0;
    m_bytesel  = '0;
    if (state == DMA_OWN) begin
      m_addr     = dma_m_addr;
      m_data_out = dma_m_data_out;
      m_access   = dma_m_access;
      m_wr_en    = dma_m_wr_en;
      d_io       = dma_d_io;
      m_bytesel  = dma_m_bytesel;
    end else if (cpu_side) begin
      m_addr     = cpu_m_addr;
      m_data_out = cpu_m_data_out;
      m_access   = cpu_m_access;
      m_wr_en    = cpu_m_wr_en;
      d_io       = cpu_d_io;
      m_bytesel  = cpu_m_bytesel;
    end
  end

  // Acks are steered with zero latency; suppressed while reset is asserted.
  assign cpu_m_ack = m_ack & ~reset & cpu_side;
  assign dma_m_ack = m_ack & ~reset & (state == DMA_OWN);

  assign cpu_m_data_in        = m_data_in;
  assign dma_m_data_in        = m_data_in;
  assign dma_hold_acknowledge = hold_ack;
  assign bus_owner_dma        = hold_ack;

endmodule
`default_nettype wire
